// File: rtl/yutorina_if_stage_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
// One outstanding word read; bus_rd_data is valid in the cycle bus_ack is high.
interface yutorina_if_stage_if;
    logic        bus_req;
    logic [29:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rd_data;

    modport master (
        output bus_req,
        output bus_addr,
        input  bus_ack,
        input  bus_rd_data
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        output bus_ack,
        output bus_rd_data
    );
endinterface

// File: rtl/yutorina_if_stage.sv
// Yutorina instruction fetch stage: fetch PC, single-outstanding bus reads, skid buffer,
// one-delay-slot branch redirect and controller flush, feeding the IF/ID register.
module yutorina_if_stage #(
    parameter logic [29:0] RESET_VECTOR = 30'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [29:0]                new_pc,
    input  logic                       br_taken,
    input  logic [29:0]                br_addr,
    yutorina_if_stage_if.master        bus,
    output logic [29:0]                if_pc,
    output logic [31:0]                if_insn,
    output logic                       if_en
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [29:0] r_pc;
    logic [29:0] w_pc_next;
    logic [29:0] r_skid_pc;
    logic [29:0] w_skid_pc_next;
    logic [31:0] r_skid_insn;
    logic [31:0] w_skid_insn_next;
    logic        r_br_pend;
    logic        w_br_pend_next;
    logic [29:0] r_br_tgt;
    logic [29:0] w_br_tgt_next;
    logic [29:0] r_drain_addr;
    logic [29:0] w_drain_addr_next;
    logic [29:0] r_if_pc;
    logic [29:0] w_if_pc_next;
    logic [31:0] r_if_insn;
    logic [31:0] w_if_insn_next;
    logic        r_if_en;
    logic        w_if_en_next;

    logic        w_bus_req;
    logic [29:0] w_bus_addr;
    logic        w_br_acc;
    logic        w_slot_now;
    logic        w_slot_skid;
    logic [29:0] w_ack_pc;

    // Bus request drops only while the skid holds an instruction the decoder has not taken.
    assign w_bus_req  = !reset && (r_state != ST_FULL);
    assign w_bus_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;

    assign bus.bus_req  = w_bus_req;
    assign bus.bus_addr = w_bus_addr;

    assign w_br_acc    = br_taken && r_if_en && !stall && !flush;
    assign w_slot_now  = w_br_acc && (r_pc == r_if_pc + 30'd1);
    assign w_slot_skid = w_br_acc && (r_pc == r_if_pc + 30'd2);

    // PC after an ack: a pending branch wins, then a branch whose delay slot is arriving now.
    assign w_ack_pc = r_br_pend  ? r_br_tgt :
                      w_slot_now ? br_addr  :
                                   r_pc + 30'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_VECTOR;
            r_skid_pc    <= '0;
            r_skid_insn  <= NOP_INSN;
            r_br_pend    <= 1'b0;
            r_br_tgt     <= '0;
            r_drain_addr <= '0;
            r_if_pc      <= RESET_VECTOR;
            r_if_insn    <= NOP_INSN;
            r_if_en      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_skid_pc    <= w_skid_pc_next;
            r_skid_insn  <= w_skid_insn_next;
            r_br_pend    <= w_br_pend_next;
            r_br_tgt     <= w_br_tgt_next;
            r_drain_addr <= w_drain_addr_next;
            r_if_pc      <= w_if_pc_next;
            r_if_insn    <= w_if_insn_next;
            r_if_en      <= w_if_en_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_skid_pc_next    = r_skid_pc;
        w_skid_insn_next  = r_skid_insn;
        w_br_pend_next    = r_br_pend;
        w_br_tgt_next     = r_br_tgt;
        w_drain_addr_next = r_drain_addr;
        w_if_pc_next      = r_if_pc;
        w_if_insn_next    = r_if_insn;
        w_if_en_next      = r_if_en;

        if (flush) begin
            w_if_en_next   = 1'b0;
            w_if_insn_next = NOP_INSN;
            w_pc_next      = new_pc;
            w_br_pend_next = 1'b0;
            // An unacked read cannot be withdrawn, so its data must be absorbed in DRAIN.
            if (r_state == ST_FETCH && w_bus_req && !bus.bus_ack) begin
                w_drain_addr_next = w_bus_addr;
                w_state_next      = ST_DRAIN;
            end else if (r_state == ST_DRAIN && !bus.bus_ack) begin
                w_state_next = ST_DRAIN;
            end else begin
                w_state_next = ST_FETCH;
            end
        end else begin
            unique case (r_state)
                ST_FETCH: begin
                    if (bus.bus_ack) begin
                        w_pc_next      = w_ack_pc;
                        w_br_pend_next = 1'b0;
                        if (!stall) begin
                            w_if_pc_next   = r_pc;
                            w_if_insn_next = bus.bus_rd_data;
                            w_if_en_next   = 1'b1;
                        end else begin
                            w_skid_pc_next   = r_pc;
                            w_skid_insn_next = bus.bus_rd_data;
                            w_state_next     = ST_FULL;
                        end
                    end else begin
                        if (!stall) begin
                            w_if_en_next   = 1'b0;
                            w_if_insn_next = NOP_INSN;
                        end
                        // Delay slot still in flight: remember the target until it lands.
                        if (w_slot_now) begin
                            w_br_pend_next = 1'b1;
                            w_br_tgt_next  = br_addr;
                        end
                    end
                end
                ST_FULL: begin
                    if (!stall) begin
                        w_if_pc_next   = r_skid_pc;
                        w_if_insn_next = r_skid_insn;
                        w_if_en_next   = 1'b1;
                        w_state_next   = ST_FETCH;
                    end
                    if (w_slot_skid) begin
                        w_pc_next = br_addr;
                    end
                end
                ST_DRAIN: begin
                    if (bus.bus_ack) begin
                        w_state_next = ST_FETCH;
                    end
                end
                default: begin
                    w_state_next = ST_FETCH;
                end
            endcase
        end
    end

    assign if_pc   = r_if_pc;
    assign if_insn = r_if_insn;
    assign if_en   = r_if_en;

endmodule

// File: doc/yutorina_if_stage.md
# yutorina_if_stage

Instruction fetch stage for the Yutorina CPU. It owns the fetch PC, issues one-outstanding word reads on the instruction bus, and drives the IF/ID pipeline register (`if_pc`, `if_insn`, `if_en`) consumed by the instruction decoder. It takes the decoder's `br_taken`/`br_addr` back as redirect inputs, with one architectural delay slot. It also accepts flush/`new_pc` from the CPU controller for exception entry and ERET.

## Interface
- `RESET_VECTOR`, default 30'h0000_0000: word address of the first fetch after reset.
- `NOP_INSN`, default 32'h0000_0000: instruction presented on `if_insn` for bubbles and flushes.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: decode stage cannot accept a new instruction this cycle.
- `flush` in 1: controller redirect to `new_pc`.
- `new_pc` in 30: flush target word address.
- `br_taken` in 1: decoder's branch decision for the instruction currently on `if_insn`.
- `br_addr` in 30: branch target word address.
- `bus_req` out 1: fetch request.
- `bus_addr` out 30: fetch word address. Held stable while `bus_req`=1 and `bus_ack`=0.
- `bus_ack` in 1: read complete this cycle. `bus_rd_data` is valid in the same cycle.
- `bus_rd_data` in 32: fetched instruction word.
- `if_pc` out 30: word address of the instruction on `if_insn`.
- `if_insn` out 32: instruction to the decoder.
- `if_en` out 1: `if_insn` is valid.

## Operation
- State registers: `pc`, `state` ∈ {FETCH, FULL, DRAIN}, skid buffer (`skid_insn`, `skid_pc`), `br_pend`, `br_tgt`, `drain_addr`.
- Bus outputs:
  - `bus_req` = 0 while `reset`=1 or `state`=FULL; otherwise 1.
  - `bus_addr` = `drain_addr` in DRAIN; otherwise `pc`.
- A branch is accepted when `br_taken` & `if_en` & !`stall` & !`flush`. The delay slot is the instruction at `if_pc`+1.
- FETCH behaviour:
  - `bus_ack` & !`stall`: output register loads {`pc`, `bus_rd_data`, `if_en`=1}; `pc` advances to next-pc.
  - `bus_ack` & `stall`: skid loads {`pc`, `bus_rd_data`}; `pc` advances to next-pc; go to FULL. Output register holds.
  - !`bus_ack` & !`stall`: bubble: `if_en`=0, `if_insn`=`NOP_INSN`, `if_pc` holds.
  - !`bus_ack` & `stall`: everything holds.
- Next-pc on an ack:
  - `br_pend`=1: `br_tgt`, then clear `br_pend`.
  - Else, branch accepted this cycle with `pc`==`if_pc`+1: `br_addr`, because the delay slot is being captured now.
  - Else: `pc`+1.
- Branch accepted while `pc`==`if_pc`+1 with no ack: `br_pend`←1, `br_tgt`←`br_addr`.
- FULL behaviour:
  - !`stall`: output register loads the skid contents with `if_en`=1; go to FETCH.
  - A branch accepted in FULL (here `pc`==`if_pc`+2, delay slot in skid) sets `pc`←`br_addr` directly.
- Flush has top priority, in any state:
  - Outputs become `if_en`=0, `if_insn`=`NOP_INSN`.
  - `pc`←`new_pc`; `br_pend`←0; skid is discarded.
  - If in FETCH with `bus_req`=1 and no ack this cycle: `drain_addr`←`bus_addr`, go to DRAIN. Otherwise go to FETCH.
- DRAIN:
  - `bus_req` stays high at `drain_addr` until `bus_ack`. The returned data is discarded; then go to FETCH.
  - A flush during DRAIN updates `pc` and stays in DRAIN.
- Branch inputs are ignored whenever `if_en`=0.
- All PC arithmetic is modulo 2^30: 30'h3FFF_FFFF+1 = 0, including the `if_pc`+1/+2 comparisons.

## Timing
- Reset values: `pc`=`RESET_VECTOR`, `state`=FETCH, `if_en`=0, `if_insn`=`NOP_INSN`, `if_pc`=`RESET_VECTOR`, `br_pend`=0. `bus_req`=0 during reset.
- First request is issued in the first cycle with `reset`=0.
- Latency: `bus_ack` in cycle N (no stall) → `if_en`/`if_insn` valid in cycle N+1.
- Zero-wait bus: one instruction per cycle.
- A new request address appears in the cycle after the ack. A request is never withdrawn once raised.
- Reset mid-request abandons the request. The bus is reset by the same `reset`.
- Simultaneous `flush` & `br_taken`: flush wins. Simultaneous `flush` & `bus_ack` in FETCH: data is dropped, and the next request goes to `new_pc` with no DRAIN.

## Test plan
- Reset, then `bus_ack`=1 on every request → `bus_addr` 0,1,2,3…; `if_pc` 0,1,2 with `if_en`=1 from the second cycle after reset release.
- `stall`=1 for 3 cycles spanning an ack at addr 5 → `bus_req` drops in FULL; on release `if_pc`=5 and the next request is addr 6.
- Branch at `if_pc`=0x10 to 0x40, ack for 0x11 delayed 2 cycles → fetch order 0x11, 0x40; `br_pend` set then cleared.
- Branch accepted while in FULL with the delay slot 0x21 in skid → next `bus_addr`=`br_addr`, and 0x21 is delivered before the target.
- `flush` with `new_pc`=0x100 while a request to 0x8 is outstanding, ack 3 cycles later → 0x8 data never reaches `if_insn`, next `bus_addr`=0x100, `if_en`=0 throughout.
- `RESET_VECTOR`=30'h3FFF_FFFF → second `bus_addr`=0. Same-cycle `flush`+`br_taken` → target = `new_pc`.
